// File: rtl/gf_mul_128_sched.sv
// Single-slot scheduler that shares one GF(2^128) multiplier between two requesters.
// Define GF_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module gf_mul_128_sched #(
  parameter int          MUL_LAT = 2,
  parameter logic [21:0] CG1_RST = 22'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [21:0]  cfg_cg1,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [255:0] req_a,
  input  logic [255:0] req_b,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [127:0] rsp_c,
  output logic [127:0] mul_a,
  output logic [127:0] mul_b,
  output logic [21:0]  mul_cg1,
  output logic         mul_rst_n,
  input  logic [127:0] mul_c,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(MUL_LAT - 1);

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic [127:0] rsp_c_q;
  logic [21:0]  cg1;
  logic         owner;
  logic         winner;
  logic         accept;
  logic         rsp_fire;

`ifdef GF_SCHED_RR_EN
  // prio names the requester that wins a tie; it flips away from each granted requester.
  logic prio;

  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b11) winner = prio;
    else                    winner = req_valid[1];
  end
`else
  always_comb begin
    winner = 1'b0;
    if (!req_valid[0]) winner = 1'b1;
  end
`endif

  // Configuration writes take precedence over requests in IDLE.
  assign accept   = (state == IDLE) && !cfg_we && !rst && (req_valid != 2'b00);
  assign rsp_fire = (state == RSP) && rsp_ready[owner];

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready = winner ? 2'b10 : 2'b01;
  end

  always_comb begin
    rsp_valid = 2'b00;
    if ((state == RSP) && !rst) rsp_valid = owner ? 2'b10 : 2'b01;
  end

  assign busy      = (state != IDLE) && !rst;
  assign rsp_c     = rsp_c_q;
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign mul_cg1   = cg1;
  assign mul_rst_n = ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      op_a    <= 128'd0;
      op_b    <= 128'd0;
      rsp_c_q <= 128'd0;
      cg1     <= CG1_RST;
      owner   <= 1'b0;
`ifdef GF_SCHED_RR_EN
      prio    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) begin
            cg1 <= cfg_cg1;
          end else if (accept) begin
            op_a  <= winner ? req_a[255:128] : req_a[127:0];
            op_b  <= winner ? req_b[255:128] : req_b[127:0];
            owner <= winner;
            cnt   <= 4'd0;
            state <= MUL;
`ifdef GF_SCHED_RR_EN
            prio  <= ~winner;
`endif
          end
        end
        MUL: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            rsp_c_q <= mul_c;
            state   <= RSP;
          end
        end
        RSP: begin
          if (rsp_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mul_128_sched.sv
// Scoreboard bench for gf_mul_128_sched with a behavioural GF(2^128) multiplier.
// Expected grant order follows GF_SCHED_RR_EN when it is defined for the build.
module tb_gf_mul_128_sched;

  localparam int          MUL_LAT = 2;
  localparam logic [21:0] CG1_RST = 22'h2A;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [21:0]  cfg_cg1;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_c;
  logic [127:0] mul_a;
  logic [127:0] mul_b;
  logic [21:0]  mul_cg1;
  logic         mul_rst_n;
  logic [127:0] mul_c;
  logic         busy;

  typedef struct {
    logic         owner;
    logic [127:0] c;
  } exp_t;

  exp_t sb[$];
  int   applied    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   accept_cyc = 0;
  logic [1:0] prev_rv = 2'b00;

  gf_mul_128_sched #(.MUL_LAT(MUL_LAT), .CG1_RST(CG1_RST)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_cg1(cfg_cg1),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .mul_a(mul_a), .mul_b(mul_b), .mul_cg1(mul_cg1), .mul_rst_n(mul_rst_n),
    .mul_c(mul_c), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Field polynomial is x^128 + cg1(x), cg1 occupying the low 22 coefficients.
  function automatic logic [127:0] gf_model(input logic [127:0] a, input logic [127:0] b,
                                            input logic [21:0] p);
    logic [127:0] r;
    logic [127:0] aa;
    logic         carry;
    r  = 128'd0;
    aa = a;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) r = r ^ aa;
      carry = aa[127];
      aa    = aa << 1;
      if (carry) aa = aa ^ {106'd0, p};
    end
    return r;
  endfunction

  assign mul_c = gf_model(mul_a, mul_b, mul_cg1);

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int id);
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) got = 1'b1;
    end
    check_output("accept_timeout", {127'd0, got}, 128'd1);
    tick();
  endtask

  task automatic apply_stimulus(input int id, input logic [127:0] a, input logic [127:0] b,
                                input logic [127:0] exp_c);
    exp_t e;
    e.owner = id[0];
    e.c     = exp_c;
    sb.push_back(e);
    req_a[id*128 +: 128] = a;
    req_b[id*128 +: 128] = b;
    req_valid[id] = 1'b1;
    wait_accept(id);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check_output("drain_timeout", {127'd0, sb.size() == 0}, 128'd1);
    tick();
  endtask

  // Monitor: measures accept-to-response latency and pops the scoreboard on each response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ((req_valid & req_ready) != 2'b00) accept_cyc = cyc;
        if (rsp_valid != 2'b00 && prev_rv == 2'b00)
          check_output("rsp_latency", 128'(cyc - accept_cyc), 128'(MUL_LAT + 1));
        if ((rsp_valid & rsp_ready) != 2'b00) begin
          if (sb.size() == 0) begin
            check_output("unexpected_rsp", {126'd0, rsp_valid}, 128'd0);
          end else begin
            e = sb.pop_front();
            check_output("rsp_owner", {126'd0, rsp_valid}, e.owner ? 128'd2 : 128'd1);
            check_output("rsp_c", rsp_c, e.c);
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  initial begin
    exp_t e;
    int   n;
    bit   seen;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_cg1   = 22'd0;
    req_valid = 2'b01;
    req_a     = 256'd0;
    req_b     = 256'd0;
    rsp_ready = 2'b11;

    // Reset state, with a request pending to show it is not granted.
    tick();
    tick();
    @(negedge clk);
    check_output("rst_req_ready", {126'd0, req_ready}, 128'd0);
    check_output("rst_rsp_valid", {126'd0, rsp_valid}, 128'd0);
    check_output("rst_busy", {127'd0, busy}, 128'd0);
    check_output("rst_mul_rst_n", {127'd0, mul_rst_n}, 128'd0);
    check_output("rst_cg1", {106'd0, mul_cg1}, {106'd0, CG1_RST});
    check_output("rst_mul_a", mul_a, 128'd0);
    check_output("rst_rsp_c", rsp_c, 128'd0);
    tick();
    rst       = 1'b0;
    req_valid = 2'b00;

    // Single op: 1 * 2 = 2.
    apply_stimulus(0, 128'h1, 128'h2, 128'h2);
    @(negedge clk);
    check_output("mul_busy", {127'd0, busy}, 128'd1);
    check_output("mul_rst_n_run", {127'd0, mul_rst_n}, 128'd1);
    check_output("mul_a_hold", mul_a, 128'h1);
    check_output("mul_b_hold", mul_b, 128'h2);
    wait_drain();

    // Configuration write in IDLE beats a pending request.
    cfg_we       = 1'b1;
    cfg_cg1      = 22'h3FFFFF;
    req_a[127:0] = 128'h9;
    req_valid    = 2'b01;
    @(negedge clk);
    check_output("cfg_blocks_ready", {126'd0, req_ready}, 128'd0);
    tick();
    cfg_we    = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    check_output("cfg_idle_write", {106'd0, mul_cg1}, 128'h3FFFFF);
    check_output("cfg_idle_busy", {127'd0, busy}, 128'd0);
    tick();

    // Configuration write during MUL is ignored: 3 * 5 = 0xF.
    apply_stimulus(0, 128'h3, 128'h5, 128'hF);
    cfg_we  = 1'b1;
    cfg_cg1 = 22'h87;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    check_output("cfg_mul_ignored", {106'd0, mul_cg1}, 128'h3FFFFF);
    wait_drain();

    // Load 0x87 and reduce x^127 * x = x^128 -> 0x87 on requester 1's lanes.
    cfg_we  = 1'b1;
    cfg_cg1 = 22'h87;
    tick();
    cfg_we = 1'b0;
    apply_stimulus(1, {1'b1, 127'd0}, 128'h2, 128'h87);
    check_output("cfg_loaded", {106'd0, mul_cg1}, 128'h87);
    wait_drain();

    // Both requesters held for four operations.
`ifdef GF_SCHED_RR_EN
    for (int i = 0; i < 4; i++) begin
      e.owner = i[0];
      e.c     = i[0] ? 128'h100 : 128'hF;
      sb.push_back(e);
    end
`else
    for (int i = 0; i < 4; i++) begin
      e.owner = 1'b0;
      e.c     = 128'hF;
      sb.push_back(e);
    end
`endif
    req_a     = {128'h10, 128'h3};
    req_b     = {128'h10, 128'h5};
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) n++;
    end
    check_output("arb_accepts", 128'(n), 128'd4);
    tick();
    req_valid = 2'b00;
    wait_drain();

    // Response held for 10 cycles: 7 * 3 = 9, non-owner accepts toggled meanwhile.
    rsp_ready = 2'b00;
    apply_stimulus(0, 128'h7, 128'h3, 128'h9);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    check_output("hold_rsp_seen", {127'd0, seen}, 128'd1);
    req_a[255:128] = 128'h4;
    req_b[255:128] = 128'h4;
    req_valid      = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      rsp_ready[1] = ~rsp_ready[1];
      @(negedge clk);
      check_output("hold_rsp_valid", {126'd0, rsp_valid}, 128'd1);
      check_output("hold_rsp_c", rsp_c, 128'h9);
      check_output("hold_req_ready", {126'd0, req_ready}, 128'd0);
      check_output("hold_busy", {127'd0, busy}, 128'd1);
    end
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    wait_drain();
    rsp_ready = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check_output("dropped_no_grant", {127'd0, busy}, 128'd0);
    tick();

    // Reset during MUL aborts the operation and restores C_g1.
    req_a[127:0] = 128'h5;
    req_b[127:0] = 128'h5;
    req_valid    = 2'b01;
    wait_accept(0);
    req_valid = 2'b00;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_busy", {127'd0, busy}, 128'd0);
    check_output("abort_rsp_valid", {126'd0, rsp_valid}, 128'd0);
    check_output("abort_cg1", {106'd0, mul_cg1}, {106'd0, CG1_RST});
    check_output("abort_mul_a", mul_a, 128'd0);
    for (int i = 0; i < 5; i++) tick();
    apply_stimulus(1, 128'h5, 128'h3, 128'hF);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/gf_mul_128_sched.md
GF_MUL_128_SCHED -- requirements
Module: gf_mul_128_sched

Interface
- REQ-001 SHALL have parameter MUL_LAT, default 2, the multiplier settle time in cycles; legal values 1..15.
- REQ-002 SHALL have parameter CG1_RST, default 22'h0, the reset value of the C_g1 configuration register.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have port cfg_we, input, 1 bit: C_g1 configuration write strobe.
- REQ-006 SHALL have port cfg_cg1, input, 22 bits: C_g1 write data.
- REQ-007 SHALL have port req_valid, input, 2 bits: bit N means requester N offers an operand pair.
- REQ-008 SHALL have port req_ready, output, 2 bits: bit N is the grant/accept to requester N.
- REQ-009 SHALL have port req_a, input, 256 bits: [127:0] carries requester 0's operand a, [255:128] requester 1's.
- REQ-010 SHALL have port req_b, input, 256 bits, packed the same way as req_a.
- REQ-011 SHALL have port rsp_valid, output, 2 bits: bit N means a result is pending for requester N.
- REQ-012 SHALL have port rsp_ready, input, 2 bits: result accept from each requester.
- REQ-013 SHALL have port rsp_c, output, 128 bits: product, shared by both requesters.
- REQ-014 SHALL have ports mul_a and mul_b, output, 128 bits each, and mul_cg1, output, 22 bits: drive to the shared GF(2^128) multiplier.
- REQ-015 SHALL have port mul_rst_n, output, 1 bit: drives the multiplier's active-low rst_n and equals ~rst.
- REQ-016 SHALL have port mul_c, input, 128 bits: the multiplier's reduced product.
- REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
- REQ-018 SHALL implement FSM states IDLE, MUL and RSP, and only one operation SHALL be in flight at a time.
- REQ-019 In IDLE with cfg_we=0 and any req_valid bit set, SHALL assert req_ready for the arbitration winner only, combinationally in the same cycle.
- REQ-020 On that handshake SHALL latch the winner's a and b into the operand registers, record the owner, clear the counter and enter MUL.
- REQ-021 In MUL SHALL increment the counter each cycle; when counter==MUL_LAT-1 SHALL register mul_c into rsp_c and enter RSP.
- REQ-022 SHALL assert rsp_valid[owner] in RSP, with accept-to-rsp_valid latency of exactly MUL_LAT+1 cycles.
- REQ-023 In RSP SHALL hold rsp_c and rsp_valid stable until rsp_ready[owner]=1, then return to IDLE; rsp_ready of the non-owner SHALL be ignored.
- REQ-024 Back-to-back operations SHALL have at least one IDLE cycle between the RSP handshake and the next accept.
- REQ-025 mul_a and mul_b SHALL come from the operand registers and stay stable through MUL and RSP; mul_cg1 SHALL come from the C_g1 register.
- REQ-026 cfg_we in IDLE SHALL load cfg_cg1 on the next edge and force req_ready=0 in that cycle (configuration wins over requests); cfg_we outside IDLE SHALL be ignored.
- REQ-027 req_ready SHALL be 0 in MUL and RSP; a requester that drops req_valid before being granted SHALL receive no grant and no result.

Reset
- REQ-028 With rst=1 at a clock edge, SHALL set state=IDLE, counter=0, operand registers=0, rsp_c=0, C_g1=CG1_RST, and the round-robin pointer so that requester 0 wins next.
- REQ-029 During reset req_ready, rsp_valid and busy SHALL be 0; reset during MUL or RSP SHALL abort the operation and never deliver its result.

Configuration
- REQ-030 Macro GF_SCHED_RR_EN defined: round-robin arbitration; on simultaneous requests the requester not granted last wins, and the pointer updates only on a req handshake.
- REQ-031 Macro GF_SCHED_RR_EN undefined: fixed priority with requester 0 always winning; no pointer register exists.

Verification
- REQ-032 Single op, MUL_LAT=2: req0 a=128'h1, b=128'h2, model mul_c=a*b -> rsp_valid[0] exactly 3 cycles after accept, rsp_c=128'h2.
- REQ-033 req_valid=2'b11 held for 4 ops with RR_EN -> grant order 0,1,0,1; without RR_EN -> 0,0,0,0.
- REQ-034 rsp_ready[0] held low 10 cycles in RSP -> rsp_c, rsp_valid stable, req_ready=0, and rsp_ready[1] pulses have no effect.
- REQ-035 rst asserted mid-MUL -> next cycle IDLE, rsp_valid=0, C_g1=CG1_RST, and a new request completes normally.
- REQ-036 cfg_we with 22'h3FFFFF during MUL -> mul_cg1 unchanged; the same write in IDLE with req_valid=1 -> req_ready=0 that cycle and mul_cg1=22'h3FFFFF next cycle.
